// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART definitions: receiver state encoding and default frame timing,
// common to the transmitter and receiver sides.
package uart_rx_ctrl_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DEFAULT_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_ctrl_sync_2ff.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle
// (high) level so reset never looks like a start bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw line through two flops to settle metastability
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: qualifies the start bit, times mid-bit samples,
// strobes each data bit into the external SIPO and checks the stop bit.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic rxin,
    input  logic en,
    output logic shift,
    output logic rx_bit,
    output logic busy,
    output logic done,
    output logic frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] bit_idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             rxs;
    logic             shift_nxt;
    logic             rx_bit_nxt;
    logic             done_nxt;
    logic             err_nxt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxin),
        .q   (rxs)
    );

    // State, counters and the registered one-cycle strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= 1'b0;
            rx_bit    <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= cnt_nxt;
            bit_idx   <= idx_nxt;
            shift     <= shift_nxt;
            rx_bit    <= rx_bit_nxt;
            done      <= done_nxt;
            frame_err <= err_nxt;
        end
    end

    // Next state and bit timing; counters clear on every terminal count
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        idx_nxt   = bit_idx;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (en && !rxs) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = rxs ? IDLE : DATA;
                end else begin
                    cnt_nxt = bit_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == IDX_LAST) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = bit_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = rxs ? IDLE : BREAK;
                end else begin
                    cnt_nxt = bit_cnt + 1'b1;
                end
            end
            BREAK: begin
                cnt_nxt = '0;
                if (rxs) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // Strobe conditions at the sample points, plus the busy flag
    always_comb begin
        shift_nxt  = (state == DATA) && (bit_cnt == BIT_LAST);
        rx_bit_nxt = shift_nxt && rxs;
        done_nxt   = (state == STOP) && (bit_cnt == BIT_LAST) && rxs;
        err_nxt    = (state == STOP) && (bit_cnt == BIT_LAST) && !rxs;
        busy       = (state != IDLE);
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: frames are driven from a table, the
// expected strobe sequence is queued up front and checked as the DUT emits it.
module tb_uart_rx_ctrl;

    localparam int CPB = 16;
    localparam int DB  = 8;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       en;
        int         gap;
    } frame_vec_t;

    typedef struct {
        logic       is_shift;
        logic       is_done;
        logic       is_err;
        logic       bit_val;
        logic [7:0] data;
        int         gap;
    } exp_evt_t;

    logic clk = 1'b0;
    logic rst;
    logic rxin;
    logic en;
    logic shift;
    logic rx_bit;
    logic busy;
    logic done;
    logic frame_err;

    int         errors = 0;
    int         checks = 0;
    int         cycle = 0;
    int         lastEvt = 0;
    int         shiftCnt = 0;
    int         busyHighCnt = 0;
    logic [7:0] sipo = 8'h00;
    exp_evt_t   expQ[$];
    int         doneCycles[$];
    frame_vec_t vecs[5];

    uart_rx_ctrl #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxin      (rxin),
        .en        (en),
        .shift     (shift),
        .rx_bit    (rx_bit),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic driveLine(input logic val, input int n);
        rxin = val;
        repeat (n) @(negedge clk);
    endtask

    task automatic pushShift(input logic b, input logic [7:0] d, input int gap);
        exp_evt_t e;
        e = '{1'b1, 1'b0, 1'b0, b, d, gap};
        expQ.push_back(e);
    endtask

    // Drive one frame on the line; queue its expected strobes when enabled
    task automatic applyStimulus(input frame_vec_t v, input bit pushExp, input int stopCycles);
        exp_evt_t e;
        en = v.en;
        if (pushExp && v.en) begin
            for (int i = 0; i < DB; i++) begin
                pushShift(v.data[i], v.data, (i == 0) ? 0 : CPB);
            end
            e = '{1'b0, v.stop_bit, !v.stop_bit, 1'b0, v.data, CPB};
            expQ.push_back(e);
        end
        driveLine(1'b0, CPB);
        for (int i = 0; i < DB; i++) begin
            driveLine(v.data[i], CPB);
        end
        driveLine(v.stop_bit, stopCycles);
        driveLine(1'b1, v.gap);
    endtask

    task automatic waitDrain(input int maxCycles);
        for (int i = 0; i < maxCycles && (busy || expQ.size() != 0); i++) begin
            @(negedge clk);
        end
        checkOutput("drain_queue", expQ.size(), 0);
        checkOutput("drain_busy", {31'd0, busy}, 0);
    endtask

    // Scoreboard: every strobe must match the head of the expected queue
    always @(negedge clk) begin
        exp_evt_t e;
        if (busy) busyHighCnt++;
        if (shift || done || frame_err) begin
            checkOutput("one_strobe", 32'(shift) + 32'(done) + 32'(frame_err), 1);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_strobe: got shift=%0b done=%0b err=%0b expected none (cycle %0d)",
                         shift, done, frame_err, cycle);
            end else begin
                e = expQ.pop_front();
                checkOutput("strobe_kind", {29'd0, shift, done, frame_err}, {29'd0, e.is_shift, e.is_done, e.is_err});
                if (shift) checkOutput("rx_bit", {31'd0, rx_bit}, {31'd0, e.bit_val});
                if (e.gap != 0) checkOutput("strobe_gap", cycle - lastEvt, e.gap);
                if (done) checkOutput("sipo_byte", {24'd0, sipo}, {24'd0, e.data});
            end
            if (shift) begin
                sipo = {rx_bit, sipo[7:1]};
                shiftCnt++;
            end
            if (done) doneCycles.push_back(cycle);
            lastEvt = cycle;
        end
    end

    // Hard time limit so the run can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        frame_vec_t v;
        int target;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 20};
        vecs[1] = '{8'h01, 1'b1, 1'b1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 20};
        vecs[3] = '{8'h55, 1'b1, 1'b0, 20};
        vecs[4] = '{8'h96, 1'b1, 1'b1, 20};

        rst  = 1'b1;
        en   = 1'b1;
        rxin = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {27'd0, shift, rx_bit, busy, done, frame_err}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] table frames");
        for (int k = 0; k < 5; k++) begin
            busyHighCnt = 0;
            applyStimulus(vecs[k], 1'b1, CPB);
            if (!vecs[k].en) checkOutput("disabled_busy_cycles", busyHighCnt, 0);
            if (vecs[k].gap != 0) waitDrain(100);
        end
        checkOutput("done_count", doneCycles.size(), 4);
        if (doneCycles.size() >= 3) begin
            checkOutput("b2b_done_spacing", doneCycles[2] - doneCycles[1], 10 * CPB);
        end

        $display("[TB] start glitch");
        busyHighCnt = 0;
        driveLine(1'b0, 4);
        driveLine(1'b1, 30);
        checkOutput("glitch_busy_cycles", busyHighCnt, CPB / 2);
        checkOutput("glitch_state_idle", {31'd0, busy}, 0);

        $display("[TB] framing error with held-low line");
        v = '{8'h3C, 1'b0, 1'b1, 0};
        applyStimulus(v, 1'b1, 40);
        checkOutput("break_queue_empty", expQ.size(), 0);
        checkOutput("break_busy_held", {31'd0, busy}, 1);
        driveLine(1'b1, 4);
        checkOutput("break_exit_idle", {31'd0, busy}, 0);
        driveLine(1'b1, 20);

        $display("[TB] reset mid-frame");
        v = '{8'hF8, 1'b1, 1'b1, 40};
        target = shiftCnt + 3;
        for (int i = 0; i < 3; i++) pushShift(1'b0, 8'hF8, (i == 0) ? 0 : CPB);
        fork
            applyStimulus(v, 1'b0, CPB);
            begin
                for (int i = 0; i < 400 && shiftCnt < target; i++) @(negedge clk);
                checkOutput("third_shift_seen", shiftCnt, target);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checkOutput("midframe_reset_outputs", {27'd0, shift, rx_bit, busy, done, frame_err}, 0);
                checkOutput("midframe_reset_queue", expQ.size(), 0);
            end
        join
        waitDrain(100);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
